host_nts_descriptor_reader: RTL and testbench
=============================================

# host_nts_descriptor_reader

Read side of the host non-TS descriptor queue. Pops 13-bit descriptors from the 13x256 host queue FIFO (normal-mode read: data valid one cycle after read request) one at a time. Hands each descriptor to the host transmit engine over a req/ack handshake, waits for transmit completion, then returns the buffer id to the buffer manager. Sits between the host queue and the host transmit/buffer-free logic.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16'd4096, cycles allowed in WAIT_DONE before forced completion

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, synchronous, active-high
- i_tx_enable  in  1  host port enabled; gates start of a new descriptor only
- i_fifo_empty  in  1  host queue read-domain empty
- iv_nts_descriptor_rdata  in  13  FIFO q; bufid in [8:0], attributes in [12:9]
- o_nts_descriptor_rd  out  1  FIFO read request, one-cycle pulse
- ov_tx_descriptor  out  13  descriptor presented to transmit engine
- o_tx_req  out  1  descriptor valid, held until ack
- i_tx_ack  in  1  transmit engine accepted descriptor
- i_tx_done  in  1  one-cycle pulse, packet fully transmitted
- ov_free_bufid  out  9  bufid to release
- o_free_bufid_wr  out  1  release request, held until ack
- i_free_bufid_ack  in  1  buffer manager accepted release
- ov_debug_tx_cnt  out  16  descriptors completed normally
- ov_debug_timeout_cnt  out  16  descriptors completed by timeout

## Operation
- FSM states: IDLE, READ, LATCH, REQ, WAIT_DONE, FREE. Reset -> IDLE.
- IDLE: if i_tx_enable && !i_fifo_empty -> READ; else stay.
- READ: o_nts_descriptor_rd=1 for this cycle only -> LATCH.
- LATCH: capture iv_nts_descriptor_rdata into descriptor register -> REQ.
- REQ: o_tx_req=1, ov_tx_descriptor=latched value; on i_tx_ack=1 -> WAIT_DONE; timeout counter cleared.
- WAIT_DONE: timeout counter increments each cycle; i_tx_done=1 -> FREE (increment ov_debug_tx_cnt); counter reaching TIMEOUT_CYCLES-1 without done -> FREE (increment ov_debug_timeout_cnt). Done and timeout in the same cycle count as done.
- FREE: o_free_bufid_wr=1, ov_free_bufid=descriptor[8:0]; on i_free_bufid_ack=1 -> IDLE.
- i_tx_done outside WAIT_DONE: ignored. i_tx_ack outside REQ: ignored.
- i_tx_enable falling mid-descriptor: current descriptor completes through FREE; no new READ.
- o_nts_descriptor_rd never asserted while i_fifo_empty=1 at decision cycle; at most one descriptor outstanding.
- Debug counters: 16-bit, wrap 16'hFFFF -> 0.
- Reset mid-operation: all state discarded, in-flight buffer not released.

## Timing
- Reset values: all outputs 0; descriptor register 0; counters 0; state IDLE.
- All outputs registered (driven from state/data registers, no input-to-output combinational path).
- Cycle 0 IDLE with non-empty -> cycle 1 rd pulse -> cycle 2 LATCH samples q -> cycle 3 o_tx_req=1.
- Ack seen at cycle N -> o_tx_req=0 at N+1.
- Done seen at cycle M -> o_free_bufid_wr=1 at M+1; free ack at K -> IDLE at K+1, next rd earliest K+2.
- Minimum descriptor period with zero-wait ack/done/free-ack: 6 cycles.
- Timeout: ack at cycle N -> forced FREE at N+1+TIMEOUT_CYCLES.

## Structure
- Package host_tx_pkg: state encoding, NTS_DESC_W=13, BUFID_W=9, BUFID_LSB/MSB, DEBUG_CNT_W=16.
- Sub-module debug_counter16 (enable-incrementing wrap counter, sync active-high reset), instanced twice.
- FSM, descriptor register and timeout counter in the top module.

## Test plan
- Reset with FIFO non-empty: all outputs 0; after release, rd pulse exactly at cycle 1 after first IDLE cycle.
- FIFO holds descriptor 13'h1_0A5, ack/done/free-ack immediate: ov_tx_descriptor=13'h10A5, ov_free_bufid=9'h0A5, ov_debug_tx_cnt=1, 6-cycle period.
- Three back-to-back descriptors, ack delayed 5 cycles, done 20 cycles after ack: exactly 3 rd pulses, in-order frees, o_tx_req held stable until ack.
- TIMEOUT_CYCLES=16, no done: free asserted 17 cycles after ack, ov_debug_timeout_cnt=1, ov_debug_tx_cnt unchanged.
- i_tx_enable dropped during WAIT_DONE with FIFO non-empty: current descriptor freed, no further rd until enable returns.
- Reset asserted in WAIT_DONE: next cycle all outputs 0, state IDLE, counters 0.

Source files
------------

// File: rtl/host_tx_pkg.sv
// Shared types and widths for the host transmit path: descriptor layout,
// reader FSM state encoding and debug counter width.
package host_tx_pkg;

    localparam int NTS_DESC_W  = 13;
    localparam int BUFID_W     = 9;
    localparam int BUFID_LSB   = 0;
    localparam int BUFID_MSB   = BUFID_LSB + BUFID_W - 1;
    localparam int DEBUG_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_LATCH     = 3'd2,
        ST_REQ       = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_FREE      = 3'd5
    } nts_state_e;

endpackage

// File: rtl/debug_counter16.sv
// Free-running event counter: increments when enabled, wraps at all-ones.
module debug_counter16
    import host_tx_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    output logic [DEBUG_CNT_W-1:0] ov_cnt
);

    logic [DEBUG_CNT_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (i_en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign ov_cnt = cnt_q;

endmodule

// File: rtl/host_nts_descriptor_reader.sv
// Pops one host non-TS descriptor at a time, hands it to the transmit engine,
// waits for completion (or timeout) and returns its buffer id.
module host_nts_descriptor_reader
    import host_tx_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_tx_enable,
    input  logic                   i_fifo_empty,
    input  logic [NTS_DESC_W-1:0]  iv_nts_descriptor_rdata,
    output logic                   o_nts_descriptor_rd,
    output logic [NTS_DESC_W-1:0]  ov_tx_descriptor,
    output logic                   o_tx_req,
    input  logic                   i_tx_ack,
    input  logic                   i_tx_done,
    output logic [BUFID_W-1:0]     ov_free_bufid,
    output logic                   o_free_bufid_wr,
    input  logic                   i_free_bufid_ack,
    output logic [DEBUG_CNT_W-1:0] ov_debug_tx_cnt,
    output logic [DEBUG_CNT_W-1:0] ov_debug_timeout_cnt
);

    nts_state_e            state_q;
    logic [NTS_DESC_W-1:0] desc_q;
    logic [BUFID_W-1:0]    free_bufid_q;
    logic [15:0]           tmo_q;
    logic                  rd_q;
    logic                  tx_req_q;
    logic                  free_wr_q;
    logic                  done_hit;
    logic                  tmo_hit;

    // Done wins over a timeout landing in the same cycle.
    assign done_hit = (state_q == ST_WAIT_DONE) && i_tx_done;
    assign tmo_hit  = (state_q == ST_WAIT_DONE) && !i_tx_done &&
                      (tmo_q >= TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            desc_q       <= '0;
            free_bufid_q <= '0;
            tmo_q        <= '0;
            rd_q         <= 1'b0;
            tx_req_q     <= 1'b0;
            free_wr_q    <= 1'b0;
        end else begin
            rd_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_tx_enable && !i_fifo_empty) begin
                        rd_q    <= 1'b1;
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    // FIFO q is valid the cycle after the read request.
                    desc_q   <= iv_nts_descriptor_rdata;
                    tx_req_q <= 1'b1;
                    state_q  <= ST_REQ;
                end
                ST_REQ: begin
                    if (i_tx_ack) begin
                        tx_req_q <= 1'b0;
                        tmo_q    <= '0;
                        state_q  <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    tmo_q <= tmo_q + 16'd1;
                    if (done_hit || tmo_hit) begin
                        free_bufid_q <= desc_q[BUFID_MSB:BUFID_LSB];
                        free_wr_q    <= 1'b1;
                        state_q      <= ST_FREE;
                    end
                end
                ST_FREE: begin
                    if (i_free_bufid_ack) begin
                        free_wr_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    debug_counter16 u_tx_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (done_hit),
        .ov_cnt (ov_debug_tx_cnt)
    );

    debug_counter16 u_timeout_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (tmo_hit),
        .ov_cnt (ov_debug_timeout_cnt)
    );

    assign o_nts_descriptor_rd = rd_q;
    assign ov_tx_descriptor    = desc_q;
    assign o_tx_req            = tx_req_q;
    assign ov_free_bufid       = free_bufid_q;
    assign o_free_bufid_wr     = free_wr_q;

endmodule

// File: tb/tb_host_nts_descriptor_reader.sv
// Scoreboard bench for host_nts_descriptor_reader: a FIFO model and an
// auto-responding transmit engine / buffer manager drive one of two instances.
module tb_host_nts_descriptor_reader;

    localparam logic [15:0] TMO_T = 16'd16;

    logic        clk;
    logic        rst_m, rst_t, sel_t;
    logic        en, empty, ack, done, fack;
    logic [12:0] rdata;

    logic        m_rd, m_req, m_free_wr, t_rd, t_req, t_free_wr;
    logic [12:0] m_desc, t_desc;
    logic [8:0]  m_bufid, t_bufid;
    logic [15:0] m_txc, m_tmoc, t_txc, t_tmoc;

    logic        o_rd, o_req, o_free_wr;
    logic [12:0] o_desc;
    logic [8:0]  o_bufid;
    logic [15:0] o_txc, o_tmoc;

    host_nts_descriptor_reader u_dut_m (
        .i_clk(clk), .i_rst(rst_m), .i_tx_enable(en), .i_fifo_empty(empty),
        .iv_nts_descriptor_rdata(rdata), .o_nts_descriptor_rd(m_rd),
        .ov_tx_descriptor(m_desc), .o_tx_req(m_req), .i_tx_ack(ack), .i_tx_done(done),
        .ov_free_bufid(m_bufid), .o_free_bufid_wr(m_free_wr), .i_free_bufid_ack(fack),
        .ov_debug_tx_cnt(m_txc), .ov_debug_timeout_cnt(m_tmoc)
    );

    host_nts_descriptor_reader #(.TIMEOUT_CYCLES(TMO_T)) u_dut_t (
        .i_clk(clk), .i_rst(rst_t), .i_tx_enable(en), .i_fifo_empty(empty),
        .iv_nts_descriptor_rdata(rdata), .o_nts_descriptor_rd(t_rd),
        .ov_tx_descriptor(t_desc), .o_tx_req(t_req), .i_tx_ack(ack), .i_tx_done(done),
        .ov_free_bufid(t_bufid), .o_free_bufid_wr(t_free_wr), .i_free_bufid_ack(fack),
        .ov_debug_tx_cnt(t_txc), .ov_debug_timeout_cnt(t_tmoc)
    );

    assign o_rd      = sel_t ? t_rd      : m_rd;
    assign o_req     = sel_t ? t_req     : m_req;
    assign o_free_wr = sel_t ? t_free_wr : m_free_wr;
    assign o_desc    = sel_t ? t_desc    : m_desc;
    assign o_bufid   = sel_t ? t_bufid   : m_bufid;
    assign o_txc     = sel_t ? t_txc     : m_txc;
    assign o_tmoc    = sel_t ? t_tmoc    : m_tmoc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    logic [12:0] fifo[$];
    logic [12:0] exp_tx[$];
    logic [8:0]  exp_free[$];

    int ack_dly = 0, done_dly = 0, fack_dly = 0;
    int acnt = 0, dcnt = 0, fcnt = 0;
    bit waiting = 0, done_en = 1, exp_timeout = 0;
    bit prev_req = 0, prev_free = 0;
    int rd_count = 0, free_count = 0;
    int last_rd_cyc = -100, exp_period = 0;
    int ack_cyc = 0, done_cyc = 0;
    int exp_txc = 0, exp_tmoc = 0;
    logic [12:0] req_desc = '0;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_desc(input logic [12:0] d);
        fifo.push_back(d);
        exp_tx.push_back(d);
        exp_free.push_back(d[8:0]);
        empty = 1'b0;
    endtask

    // One clock: observe outputs at the falling edge, then drive responses.
    task automatic tick();
        bit ack_prev;
        @(negedge clk);
        if (o_rd) begin
            rd_count++;
            check("rd_not_empty", int'(fifo.size() != 0), 1);
            if (exp_period != 0 && last_rd_cyc >= 0)
                check("rd_period", cyc - last_rd_cyc, exp_period);
            last_rd_cyc = cyc;
            if (fifo.size() != 0) rdata = fifo.pop_front();
            empty = (fifo.size() == 0);
        end
        if (o_req && !prev_req) begin
            check("rd_to_req", cyc - last_rd_cyc, 2);
            check("tx_expected", int'(exp_tx.size() != 0), 1);
            if (exp_tx.size() != 0) check("tx_desc", int'(o_desc), int'(exp_tx.pop_front()));
            req_desc = o_desc;
        end
        prev_req = o_req;
        if (o_free_wr && !prev_free) begin
            free_count++;
            check("free_expected", int'(exp_free.size() != 0), 1);
            if (exp_free.size() != 0) check("free_bufid", int'(o_bufid), int'(exp_free.pop_front()));
            if (exp_timeout) begin
                exp_tmoc++;
                check("ack_to_tmo_free", cyc - ack_cyc, int'(TMO_T) + 1);
            end else begin
                exp_txc++;
                check("done_to_free", cyc - done_cyc, 1);
            end
            check("tx_cnt", int'(o_txc), exp_txc);
            check("tmo_cnt", int'(o_tmoc), exp_tmoc);
        end
        prev_free = o_free_wr;

        ack_prev = ack;
        if (ack_prev) begin
            waiting = 1;
            dcnt = 0;
        end
        if (done) begin
            done = 1'b0;
        end else if (waiting && done_en) begin
            if (dcnt == done_dly) begin
                done = 1'b1;
                waiting = 0;
                done_cyc = cyc;
            end else dcnt++;
        end
        if (o_req && !ack) begin
            if (acnt == ack_dly) begin
                ack = 1'b1;
                ack_cyc = cyc;
                check("req_stable", int'(o_desc), int'(req_desc));
            end else acnt++;
        end else begin
            ack = 1'b0;
            acnt = 0;
        end
        if (o_free_wr && !fack) begin
            if (fcnt == fack_dly) fack = 1'b1;
            else fcnt++;
        end else begin
            fack = 1'b0;
            fcnt = 0;
        end
    endtask

    task automatic wait_frees(input int target, input int limit);
        int n = 0;
        while (free_count < target && n < limit) begin
            tick();
            n++;
        end
        check("free_within_budget", free_count, target);
    endtask

    task automatic wait_ack(input int limit);
        int n = 0;
        while (!ack && n < limit) begin
            tick();
            n++;
        end
        check("ack_within_budget", int'(ack), 1);
    endtask

    int base;

    initial begin
        rst_m = 1'b1; rst_t = 1'b1; sel_t = 1'b0;
        en = 1'b1; empty = 1'b1; rdata = '0;
        ack = 1'b0; done = 1'b0; fack = 1'b0;

        // Reset held with the FIFO non-empty.
        push_desc(13'h10A5);
        push_desc(13'h0E3C);
        repeat (3) tick();
        check("rst_rd", int'(m_rd), 0);
        check("rst_req", int'(m_req), 0);
        check("rst_desc", int'(m_desc), 0);
        check("rst_free_wr", int'(m_free_wr), 0);
        check("rst_bufid", int'(m_bufid), 0);
        check("rst_tx_cnt", int'(m_txc), 0);
        check("rst_tmo_cnt", int'(m_tmoc), 0);

        // Zero-wait handshakes: first rd one cycle after release, 6-cycle period.
        exp_period = 6;
        rst_m = 1'b0;
        tick();
        check("rd_first_cycle", int'(m_rd), 1);
        tick();
        check("rd_one_pulse", int'(m_rd), 0);
        wait_frees(2, 60);
        repeat (3) tick();
        exp_period = 0;

        // Three back-to-back descriptors, slow ack and done.
        ack_dly = 5; done_dly = 20; fack_dly = 2;
        base = rd_count;
        push_desc(13'h1FFF);
        push_desc(13'h0100);
        push_desc(13'h0A5A);
        wait_frees(free_count + 3, 400);
        repeat (5) tick();
        check("rd_pulses_3", rd_count - base, 3);

        // Enable dropped while waiting for done.
        ack_dly = 0; done_dly = 10; fack_dly = 0;
        push_desc(13'h1234);
        push_desc(13'h0C0F);
        wait_ack(50);
        en = 1'b0;
        base = rd_count;
        wait_frees(free_count + 1, 100);
        repeat (20) tick();
        check("rd_while_disabled", rd_count - base, 0);
        check("fifo_still_held", fifo.size(), 1);
        en = 1'b1;
        wait_frees(free_count + 1, 100);
        check("rd_after_enable", rd_count - base, 1);
        repeat (3) tick();

        // Short-timeout instance: no done, forced free 17 cycles after ack.
        rst_m = 1'b1; rst_t = 1'b0; sel_t = 1'b1;
        exp_txc = 0; exp_tmoc = 0;
        exp_timeout = 1; done_en = 0;
        tick();
        push_desc(13'h13C3);
        wait_frees(free_count + 1, 100);
        repeat (3) tick();
        exp_timeout = 0; done_en = 1; done_dly = 3;
        push_desc(13'h0777);
        wait_frees(free_count + 1, 100);
        repeat (3) tick();

        // Reset while in WAIT_DONE discards the in-flight buffer.
        done_en = 0;
        push_desc(13'h0ABC);
        wait_ack(50);
        repeat (3) tick();
        rst_t = 1'b1;
        ack = 1'b0; done = 1'b0; fack = 1'b0; waiting = 0;
        exp_free.delete();
        tick();
        check("rst2_req", int'(t_req), 0);
        check("rst2_free_wr", int'(t_free_wr), 0);
        check("rst2_desc", int'(t_desc), 0);
        check("rst2_tx_cnt", int'(t_txc), 0);
        check("rst2_tmo_cnt", int'(t_tmoc), 0);
        rst_t = 1'b0;
        exp_txc = 0; exp_tmoc = 0; done_en = 1;
        base = rd_count;
        repeat (8) tick();
        check("no_rd_after_rst", rd_count - base, 0);
        check("no_free_after_rst", int'(t_free_wr), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
